div_share_ctrl: RTL

- Controller that time-shares one divider2 instance between NR_REQ independent requesters.
- Arbitrates requests round-robin and latches each winner's operands.
- Sequences the divider's en/Busy/Ready handshake, including the mandatory en-low re-arm gap.
- Returns each result on a shared response bus with a per-requester valid strobe; adds divide-by-zero bypass and a hang timeout.

---
 rtl/div_share_pkg.sv | 32 +++
 rtl/div_share_ctrl_rr_pick.sv | 38 +++
 rtl/div_share_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_share_pkg.sv
//==============================================================================
// Module  : div_share_pkg
// Brief   : Shared types and constants for the time-shared divider controller.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package div_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int c_timeout_def = 64;

    // A timer of this width can hold TIMEOUT-1.
    function automatic int tmr_width(input int t);
        return (t < 3) ? 1 : $clog2(t);
    endfunction

    localparam int c_tmr_w_def = tmr_width(c_timeout_def);

    localparam logic [1:0] c_err_none = 2'd0;
    localparam logic [1:0] c_err_div0 = 2'd1;
    localparam logic [1:0] c_err_tmo  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/div_share_ctrl_rr_pick.sv
//==============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin select, searching upward from ptr+1.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick #(
    parameter int NR_REQ = 4,
    parameter int PTR_W  = 2
) (
    input  logic [NR_REQ-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [PTR_W-1:0]  grant,
    output logic              any
);

    logic [PTR_W:0] w_idx;

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        any   = |req;
        w_idx = '0;
        for (int k = NR_REQ; k >= 1; k--) begin
            w_idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(NR_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(NR_REQ);
            end
            if (req[w_idx[PTR_W-1:0]]) begin
                grant = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_share_ctrl.sv
//==============================================================================
// Module  : div_share_ctrl
// Brief   : Time-shares one divider between NR_REQ requesters (RR arbitration).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int NR_REQ  = 4,
    parameter int WIDTH   = 12,
    parameter int TIMEOUT = c_timeout_def
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NR_REQ-1:0]       req_valid,
    input  logic [NR_REQ*WIDTH-1:0] req_dividend,
    input  logic [NR_REQ*WIDTH-1:0] req_divisor,
    output logic [NR_REQ-1:0]       req_ready,
    output logic [NR_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]        resp_res,
    output logic                    resp_err,
    output logic                    div_en,
    output logic [WIDTH-1:0]        div_dividend,
    output logic [WIDTH-1:0]        div_divisor,
    input  logic [WIDTH-1:0]        div_res,
    input  logic                    div_busy,
    input  logic                    div_ready
);

    localparam int c_ptr_w = $clog2(NR_REQ);
    localparam int c_tmr_w = tmr_width(TIMEOUT);
    localparam logic [c_ptr_w-1:0] c_ptr_rst = c_ptr_w'(NR_REQ - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_max = c_tmr_w'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ptr_w-1:0]  r_ptr;
    logic [c_ptr_w-1:0]  r_gnt;
    logic [WIDTH-1:0]    r_dvd;
    logic [WIDTH-1:0]    r_dvs;
    logic [WIDTH-1:0]    r_res;
    logic [1:0]          r_err;
    logic [c_tmr_w-1:0]  r_timer;
    logic                r_started;

    logic [c_ptr_w-1:0]  w_gnt;
    logic                w_any;
    logic [WIDTH-1:0]    w_sel_dvd;
    logic [WIDTH-1:0]    w_sel_dvs;
    logic                w_accept;
    logic                w_div0;
    logic                w_done;
    logic                w_tmo;
    logic [NR_REQ-1:0]   w_gnt_oh;
    logic [NR_REQ-1:0]   w_act_oh;

    rr_pick #(
        .NR_REQ (NR_REQ),
        .PTR_W  (c_ptr_w)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (r_ptr),
        .grant  (w_gnt),
        .any    (w_any)
    );

    assign w_sel_dvd = req_dividend[int'(w_gnt)*WIDTH +: WIDTH];
    assign w_sel_dvs = req_divisor[int'(w_gnt)*WIDTH +: WIDTH];

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_div0      = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_div0      = (w_sel_dvs == '0);
                    w_state_nxt = w_div0 ? RESP : RUN;
                end
            end
            RUN: begin
                // Ready is only trusted once Busy has been seen; before that it is stale.
                if (r_started && div_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_timer == c_tmr_max) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = GAP;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        w_gnt_oh        = '0;
        w_gnt_oh[w_gnt] = 1'b1;
        w_act_oh        = '0;
        w_act_oh[r_gnt] = 1'b1;
        req_ready       = (w_accept && !rst) ? w_gnt_oh : '0;
        resp_valid      = '0;
        resp_res        = '0;
        resp_err        = 1'b0;
        if (r_state == RESP) begin
            resp_valid = w_act_oh;
            resp_res   = r_res;
            resp_err   = (r_err != c_err_none);
        end
        div_en       = (r_state == RUN);
        div_dividend = r_dvd;
        div_divisor  = r_dvs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= c_ptr_rst;
            r_gnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_res     <= '0;
            r_err     <= c_err_none;
            r_timer   <= '0;
            r_started <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_gnt     <= w_gnt;
                        r_ptr     <= w_gnt;
                        r_dvd     <= w_sel_dvd;
                        r_dvs     <= w_sel_dvs;
                        r_timer   <= '0;
                        r_started <= 1'b0;
                        r_res     <= '0;
                        r_err     <= w_div0 ? c_err_div0 : c_err_none;
                    end
                end
                RUN: begin
                    if (div_busy) begin
                        r_started <= 1'b1;
                    end
                    if (w_done) begin
                        r_res <= div_res;
                        r_err <= c_err_none;
                    end else if (w_tmo) begin
                        r_res <= '0;
                        r_err <= c_err_tmo;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RESP: begin
                    r_timer   <= '0;
                    r_started <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
